// File: rtl/multi_debounce.sv
`default_nettype none
// ============================================================================
// Module      : multi_debounce
// Description : NUM_CH-channel button/switch debouncer. Each channel has a
//               2-FF synchroniser, an integrating stability counter, a
//               debounced level and one-cycle rise/fall pulses. any_change
//               flags a pulse on any channel in the same cycle.
//               Define MULTI_DEBOUNCE_LONG_PRESS_EN to add a per-channel
//               long-press detector; otherwise long_press is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_debounce #(
  parameter int   NUM_CH     = 4,
  parameter int   CNT_W      = 16,
  parameter int   STABLE_CNT = 50000,
  parameter logic RESET_VAL  = 1'b0,
  parameter int   LONG_W     = 24,
  parameter int   LONG_CNT   = 4000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] db_out,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              any_change,
  output logic [NUM_CH-1:0] long_press
);

  // Terminal count value: reaching it with a still-differing input flips db.
  localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(STABLE_CNT - 1);

  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] db_q,   db_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic              any_q,  any_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  // Two-stage synchroniser for the raw asynchronous inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= {NUM_CH{RESET_VAL}};
      sync2_q <= {NUM_CH{RESET_VAL}};
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Stability counter per channel: any return to the current level restarts it.
  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == C_STABLE_LAST) begin
          db_d[i]   = sync2_q[i];
          rise_d[i] = sync2_q[i];
          fall_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  // Debounced state, counters and registered event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q   <= {NUM_CH{RESET_VAL}};
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign db_out     = db_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign any_change = any_q;

`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] C_LONG_LAST = LONG_W'(LONG_CNT - 1);
  localparam logic [LONG_W-1:0] C_LONG_MAX  = LONG_W'(LONG_CNT);

  logic [LONG_W-1:0] hold_q [NUM_CH];
  logic [LONG_W-1:0] hold_d [NUM_CH];
  logic [NUM_CH-1:0] lp_q, lp_d;

  // Hold counter runs while the debounced level is high and parks at LONG_CNT,
  // so the pulse fires once per press.
  always_comb begin
    lp_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hold_d[i] = hold_q[i];
      if (!db_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != C_LONG_MAX) begin
        hold_d[i] = hold_q[i] + 1'b1;
        lp_d[i]   = (hold_q[i] == C_LONG_LAST);
      end
    end
  end

  // Hold counters and registered long-press pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      lp_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      lp_q <= lp_d;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign long_press = lp_q;
`else
  // Long-press parameters are only meaningful in the long-press build; this
  // empty block keeps them referenced in the default build.
  if ((LONG_CNT < 1) || (LONG_W < 1)) begin : g_long_press_unused
  end

  assign long_press = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_debounce
// Description : Directed self-checking bench for multi_debounce with
//               NUM_CH=2, STABLE_CNT=4, RESET_VAL=0, LONG_CNT=10.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_in;
  logic [1:0] db_out;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       any_change;
  logic [1:0] long_press;

  int errors = 0;
  int checks = 0;

  multi_debounce #(
    .NUM_CH    (2),
    .CNT_W     (16),
    .STABLE_CNT(4),
    .RESET_VAL (1'b0),
    .LONG_W    (8),
    .LONG_CNT  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .db_out    (db_out),
    .rise      (rise),
    .fall      (fall),
    .any_change(any_change),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btn_in = 2'b11;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (db_out !== 2'b00) begin errors++; $display("FAIL rst_db k=%0d got=%b exp=00", k, db_out); end
      checks++; if (rise !== 2'b00) begin errors++; $display("FAIL rst_rise k=%0d got=%b exp=00", k, rise); end
      checks++; if (fall !== 2'b00) begin errors++; $display("FAIL rst_fall k=%0d got=%b exp=00", k, fall); end
      checks++; if (any_change !== 1'b0) begin errors++; $display("FAIL rst_any k=%0d got=%b exp=0", k, any_change); end
    end
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++; if (db_out !== ((k >= 6) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL post_rst_db k=%0d got=%b exp=%b", k, db_out, (k >= 6) ? 2'b11 : 2'b00); end
      checks++; if (rise !== ((k == 6) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL post_rst_rise k=%0d got=%b exp=%b", k, rise, (k == 6) ? 2'b11 : 2'b00); end
    end
  endtask

  task automatic test_release_both();
    btn_in = 2'b00;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++; if (fall !== ((k == 6) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL rel_fall k=%0d got=%b exp=%b", k, fall, (k == 6) ? 2'b11 : 2'b00); end
      checks++; if (any_change !== (k == 6)) begin errors++; $display("FAIL rel_any k=%0d got=%b exp=%b", k, any_change, (k == 6)); end
      checks++; if (rise !== 2'b00) begin errors++; $display("FAIL rel_rise k=%0d got=%b exp=00", k, rise); end
      checks++; if (db_out !== ((k >= 6) ? 2'b00 : 2'b11)) begin errors++; $display("FAIL rel_db k=%0d got=%b exp=%b", k, db_out, (k >= 6) ? 2'b00 : 2'b11); end
    end
  endtask

  task automatic test_single_press();
    btn_in = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (db_out !== ((k >= 6) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL press_db k=%0d got=%b exp=%b", k, db_out, (k >= 6) ? 2'b01 : 2'b00); end
      checks++; if (rise !== ((k == 6) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL press_rise k=%0d got=%b exp=%b", k, rise, (k == 6) ? 2'b01 : 2'b00); end
      checks++; if (any_change !== (k == 6)) begin errors++; $display("FAIL press_any k=%0d got=%b exp=%b", k, any_change, (k == 6)); end
      checks++; if (fall !== 2'b00) begin errors++; $display("FAIL press_fall k=%0d got=%b exp=00", k, fall); end
    end
  endtask

  task automatic test_bounce();
    btn_in = 2'b00;
    for (int k = 1; k <= 10; k++) tick();
    checks++; if (db_out !== 2'b00) begin errors++; $display("FAIL bounce_pre_db got=%b exp=00", db_out); end
    for (int k = 0; k < 20; k++) begin
      btn_in[0] = ((k / 2) % 2 == 0);
      tick();
      checks++; if (db_out !== 2'b00) begin errors++; $display("FAIL bounce_db k=%0d got=%b exp=00", k, db_out); end
      checks++; if (rise !== 2'b00) begin errors++; $display("FAIL bounce_rise k=%0d got=%b exp=00", k, rise); end
    end
    btn_in = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++; if (rise !== ((k == 6) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL bounce_final_rise k=%0d got=%b exp=%b", k, rise, (k == 6) ? 2'b01 : 2'b00); end
      checks++; if (db_out !== ((k >= 6) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL bounce_final_db k=%0d got=%b exp=%b", k, db_out, (k >= 6) ? 2'b01 : 2'b00); end
    end
  endtask

  task automatic test_reset_mid_count();
    btn_in = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (rise !== 2'b00) begin errors++; $display("FAIL midrst_rise k=%0d got=%b exp=00", k, rise); end
      checks++; if (db_out !== 2'b01) begin errors++; $display("FAIL midrst_db k=%0d got=%b exp=01", k, db_out); end
    end
    reset = 1'b1;
    tick();
    checks++; if (db_out !== 2'b00) begin errors++; $display("FAIL midrst_in_db got=%b exp=00", db_out); end
    checks++; if (rise !== 2'b00) begin errors++; $display("FAIL midrst_in_rise got=%b exp=00", rise); end
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++; if (db_out !== ((k >= 6) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL midrst_after_db k=%0d got=%b exp=%b", k, db_out, (k >= 6) ? 2'b11 : 2'b00); end
      checks++; if (rise !== ((k == 6) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL midrst_after_rise k=%0d got=%b exp=%b", k, rise, (k == 6) ? 2'b11 : 2'b00); end
    end
  endtask

  task automatic test_long_press();
    logic [1:0] exp_lp;
    btn_in = 2'b00;
    for (int k = 1; k <= 10; k++) tick();
    for (int rep = 0; rep < 2; rep++) begin
      btn_in = 2'b01;
      for (int k = 1; k <= 30; k++) begin
        tick();
`ifdef MULTI_DEBOUNCE_LONG_PRESS_EN
        exp_lp = (k == 16) ? 2'b01 : 2'b00;
`else
        exp_lp = 2'b00;
`endif
        checks++; if (long_press !== exp_lp) begin errors++; $display("FAIL long_press rep=%0d k=%0d got=%b exp=%b", rep, k, long_press, exp_lp); end
        if (k == 6) begin
          checks++; if (rise !== 2'b01) begin errors++; $display("FAIL long_rise rep=%0d got=%b exp=01", rep, rise); end
        end
      end
      btn_in = 2'b00;
      for (int k = 1; k <= 10; k++) begin
        tick();
        checks++; if (long_press !== 2'b00) begin errors++; $display("FAIL long_release rep=%0d k=%0d got=%b exp=00", rep, k, long_press); end
      end
      checks++; if (db_out !== 2'b00) begin errors++; $display("FAIL long_release_db rep=%0d got=%b exp=00", rep, db_out); end
    end
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 2'b00;
    test_reset();
    test_release_both();
    test_single_press();
    test_bounce();
    test_reset_mid_count();
    test_long_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
